// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder that processes one digit per clock, least-significant digit first.
// Define BCD_SUB_EN to add a 'sub' input, which makes the block compute A - B in ten's complement.
//
// state | meaning
// IDLE  | waiting for start; the last result is held on sum/carry_out/err
// ADD   | one digit of the latched operands is processed per clock
// DONE  | result is final; done pulses for this one cycle
module bcd_serial_adder #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_b,
   input  logic                  start,
`ifdef BCD_SUB_EN
   input  logic                  sub,
`endif
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   sum,
   output logic                  carry_out,
   output logic                  err
);

   localparam int IW = $clog2(DIGITS);
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADD  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [4*DIGITS-1:0] a_q, a_d;
   logic [4*DIGITS-1:0] b_q, b_d;
   logic [4*DIGITS-1:0] sum_q, sum_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                carry_q, carry_d;
   logic                cout_q, cout_d;
   logic                err_q, err_d;
   logic                sub_q;
   logic                sub_in;

   logic [3:0]          dig_a, dig_b_raw, dig_b;
   logic [4:0]          s;
   logic [3:0]          dig_wrap;

`ifdef BCD_SUB_EN
   logic                sub_d;
   assign sub_in = sub;
`else
   assign sub_in = 1'b0;
   assign sub_q  = 1'b0;
`endif

   assign dig_a     = a_q[idx_q*4 +: 4];
   assign dig_b_raw = b_q[idx_q*4 +: 4];
   assign dig_b     = sub_q ? (4'd9 - dig_b_raw) : dig_b_raw;
   assign s         = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0000, carry_q};
   // Subtracting 10 modulo 16 gives the same low nibble as (s - 10)[3:0] for every s in 10..31.
   assign dig_wrap  = s[3:0] - 4'd10;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      err_d   = err_q;
`ifdef BCD_SUB_EN
      sub_d   = sub_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               sum_d   = '0;
               err_d   = 1'b0;
               cout_d  = 1'b0;
               idx_d   = '0;
               carry_d = sub_in;
`ifdef BCD_SUB_EN
               sub_d   = sub_in;
`endif
               state_d = S_ADD;
            end
         end
         S_ADD: begin
            if (s > 5'd9) begin
               sum_d[idx_q*4 +: 4] = dig_wrap;
               carry_d             = 1'b1;
            end else begin
               sum_d[idx_q*4 +: 4] = s[3:0];
               carry_d             = 1'b0;
            end
            if (dig_a > 4'd9 || dig_b_raw > 4'd9) begin
               err_d = 1'b1;
            end
            if (idx_q == LAST_IDX) begin
               cout_d  = carry_d;
               idx_d   = '0;
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef BCD_SUB_EN
         sub_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         err_q   <= err_d;
`ifdef BCD_SUB_EN
         sub_q   <= sub_d;
`endif
      end
   end

   assign busy      = (state_q == S_ADD);
   assign done      = (state_q == S_DONE);
   assign sum       = sum_q;
   assign carry_out = cout_q;
   assign err       = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed-vector bench for bcd_serial_adder with DIGITS=4; expected sums are hand-computed.
// Define BCD_SUB_EN to also exercise the ten's-complement subtract path.
module tb_bcd_serial_adder;

   logic        clk;
   logic        rst_b;
   logic        start;
   logic        sub_r;
   logic [15:0] a, b;
   logic        busy, done, carry_out, err;
   logic [15:0] sum;

   int n_vec;
   int n_err;

   bcd_serial_adder #(.DIGITS(4)) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .start     (start),
`ifdef BCD_SUB_EN
      .sub       (sub_r),
`endif
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .carry_out (carry_out),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulses start for one edge, scrambles a/b afterwards, and waits (bounded) for done.
   // lat is the number of edges after the start edge until done is seen (-1 on timeout).
   task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                        output int lat, output int bcnt);
      a = av; b = bv; sub_r = sv; start = 1'b1;
      tick();
      start = 1'b0;
      a = av ^ 16'h3333;
      b = bv ^ 16'h5555;
      bcnt = busy ? 1 : 0;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (done) begin
            lat = k;
            break;
         end
         if (busy) bcnt++;
      end
   endtask

   task automatic test_reset();
      rst_b = 1'b0; start = 1'b0; a = '0; b = '0; sub_r = 1'b0;
      tick(); tick();
      n_vec++;
      if ({busy, done, sum, carry_out, err} !== 19'b0) begin
         n_err++;
         $display("FAIL reset_outputs: got busy=%b done=%b sum=%h co=%b err=%b, want all 0",
                  busy, done, sum, carry_out, err);
      end
      rst_b = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int lat, bcnt;
      do_op(16'h1234, 16'h5678, 1'b0, lat, bcnt);
      n_vec++;
      if (lat !== 4) begin n_err++; $display("FAIL basic_latency: got %0d want 4", lat); end
      n_vec++;
      if (bcnt !== 4) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 4", bcnt); end
      n_vec++;
      if ({sum, carry_out, err, busy} !== {16'h6912, 1'b0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL basic_result: got sum=%h co=%b err=%b busy=%b want 6912 0 0 0", sum, carry_out, err, busy);
      end
      tick();
      n_vec++;
      if (done !== 1'b0) begin n_err++; $display("FAIL done_one_cycle: got done=%b want 0", done); end
      tick(); tick();
      n_vec++;
      if ({sum, carry_out} !== {16'h6912, 1'b0}) begin
         n_err++;
         $display("FAIL result_hold: got sum=%h co=%b want 6912 0", sum, carry_out);
      end
   endtask

   task automatic test_overflow();
      int lat, bcnt;
      do_op(16'h9999, 16'h0001, 1'b0, lat, bcnt);
      n_vec++;
      if ({sum, carry_out, err} !== {16'h0000, 1'b1, 1'b0} || lat !== 4) begin
         n_err++;
         $display("FAIL overflow_9999: got sum=%h co=%b err=%b lat=%0d want 0000 1 0 4", sum, carry_out, err, lat);
      end
      tick();
      do_op(16'h0005, 16'h0005, 1'b0, lat, bcnt);
      n_vec++;
      if ({sum, carry_out, err} !== {16'h0010, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL five_plus_five: got sum=%h co=%b err=%b want 0010 0 0", sum, carry_out, err);
      end
      tick();
      do_op(16'h4567, 16'h5433, 1'b0, lat, bcnt);
      n_vec++;
      if ({sum, carry_out} !== {16'h0000, 1'b1}) begin
         n_err++;
         $display("FAIL ripple_all: got sum=%h co=%b want 0000 1", sum, carry_out);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int lat;
      a = 16'h1111; b = 16'h2222; start = 1'b1;
      tick();
      a = 16'h4444; b = 16'h4444;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (done) begin lat = k; break; end
      end
      n_vec++;
      if ({sum, carry_out} !== {16'h3333, 1'b0} || lat !== 4) begin
         n_err++;
         $display("FAIL b2b_first: got sum=%h co=%b lat=%0d want 3333 0 4", sum, carry_out, lat);
      end
      tick();
      n_vec++;
      if ({busy, done} !== 2'b00) begin
         n_err++;
         $display("FAIL b2b_idle_gap: got busy=%b done=%b want 0 0", busy, done);
      end
      tick();
      n_vec++;
      if ({busy, sum} !== {1'b1, 16'h0000}) begin
         n_err++;
         $display("FAIL b2b_second_accept: got busy=%b sum=%h want 1 0000", busy, sum);
      end
      start = 1'b0;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (done) begin lat = k; break; end
      end
      n_vec++;
      if ({sum, carry_out} !== {16'h8888, 1'b0} || lat !== 4) begin
         n_err++;
         $display("FAIL b2b_second: got sum=%h co=%b lat=%0d want 8888 0 4", sum, carry_out, lat);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int lat, bcnt, seen;
      a = 16'h1234; b = 16'h5678; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst_b = 1'b0;
      tick();
      rst_b = 1'b1;
      n_vec++;
      if ({busy, done, sum, carry_out, err} !== 19'b0) begin
         n_err++;
         $display("FAIL reset_mid_outputs: got busy=%b done=%b sum=%h co=%b err=%b want all 0",
                  busy, done, sum, carry_out, err);
      end
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (done || busy) seen++;
      end
      n_vec++;
      if (seen !== 0) begin n_err++; $display("FAIL reset_mid_no_done: got %0d active cycles want 0", seen); end
      do_op(16'h0005, 16'h0005, 1'b0, lat, bcnt);
      n_vec++;
      if ({sum, carry_out} !== {16'h0010, 1'b0} || lat !== 4) begin
         n_err++;
         $display("FAIL reset_mid_recover: got sum=%h co=%b lat=%0d want 0010 0 4", sum, carry_out, lat);
      end
      tick();
   endtask

   task automatic test_err();
      int lat, bcnt;
      do_op(16'h000A, 16'h0000, 1'b0, lat, bcnt);
      n_vec++;
      if ({sum, carry_out, err} !== {16'h0010, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL err_digit_a: got sum=%h co=%b err=%b want 0010 0 1", sum, carry_out, err);
      end
      tick(); tick();
      n_vec++;
      if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got err=%b want 1", err); end
      a = 16'h0001; b = 16'h0001; start = 1'b1;
      tick();
      start = 1'b0;
      n_vec++;
      if (err !== 1'b0) begin n_err++; $display("FAIL err_clear_at_start: got err=%b want 0", err); end
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (done) begin lat = k; break; end
      end
      n_vec++;
      if ({sum, carry_out, err} !== {16'h0002, 1'b0, 1'b0} || lat !== 4) begin
         n_err++;
         $display("FAIL err_valid_after: got sum=%h co=%b err=%b lat=%0d want 0002 0 0 4", sum, carry_out, err, lat);
      end
      tick();
      do_op(16'h00FF, 16'h00FF, 1'b0, lat, bcnt);
      n_vec++;
      if ({sum, carry_out, err} !== {16'h0154, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL err_ff_plus_ff: got sum=%h co=%b err=%b want 0154 0 1", sum, carry_out, err);
      end
      tick();
      do_op(16'h0000, 16'h0B00, 1'b0, lat, bcnt);
      n_vec++;
      if ({sum, carry_out, err} !== {16'h1100, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL err_digit_b: got sum=%h co=%b err=%b want 1100 0 1", sum, carry_out, err);
      end
      tick();
   endtask

`ifdef BCD_SUB_EN
   task automatic test_sub();
      int lat, bcnt;
      do_op(16'h0100, 16'h0001, 1'b1, lat, bcnt);
      n_vec++;
      if ({sum, carry_out, err} !== {16'h0099, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL sub_no_borrow: got sum=%h co=%b err=%b want 0099 1 0", sum, carry_out, err);
      end
      tick();
      do_op(16'h0001, 16'h0002, 1'b1, lat, bcnt);
      n_vec++;
      if ({sum, carry_out, err} !== {16'h9999, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL sub_borrow: got sum=%h co=%b err=%b want 9999 0 0", sum, carry_out, err);
      end
      tick();
      do_op(16'h0001, 16'h0002, 1'b0, lat, bcnt);
      n_vec++;
      if ({sum, carry_out} !== {16'h0003, 1'b0}) begin
         n_err++;
         $display("FAIL sub_off_adds: got sum=%h co=%b want 0003 0", sum, carry_out);
      end
      tick();
   endtask
`endif

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_basic();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      test_err();
`ifdef BCD_SUB_EN
      test_sub();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
